// File: rtl/tap_controller.sv
// -----------------------------------------------------------------------------
// tap_controller
//
// IEEE 1149.1 TAP controller. It contains:
//   - the 16-state TAP FSM,
//   - an IR_WIDTH-bit instruction register (shift stage plus update latch),
//   - the internal 1-bit bypass register.
// It drives the strobes for external data registers, the main client being the
// 32-bit identification register. It also muxes the selected serial output
// onto tdo.
//
// Optional feature, macro USERCODE_EN:
//   - defined   : USERCODE_OPCODE selects an external user data register
//                 (user_tdo).
//   - undefined : that opcode falls back to bypass and user_tdo is unused.
//
// Ports
//   tck           : test clock. Both edges are used.
//   trst          : asynchronous active-high reset.
//   tms           : test mode select, sampled on tck rising edge.
//   tdi           : serial data in.
//   tdo           : serial data out, registered on tck falling edge.
//   tdo_en        : high while in Shift-DR / Shift-IR.
//   dr_tdi        : tdi forwarded to the external data registers.
//   clock_dr      : gated tck. Pulses in Capture-DR and Shift-DR.
//   capture_dr    : high during Capture-DR.
//   shift_dr      : high during Shift-DR.
//   update_dr     : high for the low half-cycle of tck in Update-DR.
//   select_idcode : current instruction is IDCODE.
//   idcode_tdo    : serial output of the identification register.
//   user_tdo      : serial output of the user data register.
//   instruction   : current instruction.
// -----------------------------------------------------------------------------
module tap_controller #(
  parameter int                  IR_WIDTH        = 4,
  parameter logic [IR_WIDTH-1:0] IDCODE_OPCODE   = 4'b0001,
  parameter logic [IR_WIDTH-1:0] BYPASS_OPCODE   = 4'b1111,
  parameter logic [IR_WIDTH-1:0] USERCODE_OPCODE = 4'b0010
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic                dr_tdi,
  output logic                clock_dr,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                select_idcode,
  input  logic                idcode_tdo,
  input  logic                user_tdo,
  output logic [IR_WIDTH-1:0] instruction
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  // Capture-IR pattern: the two LSBs are 01 and every other bit is 0.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_t            r_state;
  tap_state_t            w_next;
  logic [IR_WIDTH-1:0]   r_ir_shift;
  logic [IR_WIDTH-1:0]   r_instruction;
  logic                  r_bypass;
  logic                  r_tdo;
  logic                  r_tdo_en;
  logic                  r_capture_dr;
  logic                  r_shift_dr;
  logic                  r_update_en;
  logic                  r_dr_clk_en;
  logic                  w_sel_idcode;
  logic                  w_dr_tdo;

  // TAP state transition table.
  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:     w_next = tms ? TLR    : RTI;
      RTI:     w_next = tms ? SEL_DR : RTI;
      SEL_DR:  w_next = tms ? SEL_IR : CAP_DR;
      CAP_DR:  w_next = tms ? EX1_DR : SH_DR;
      SH_DR:   w_next = tms ? EX1_DR : SH_DR;
      EX1_DR:  w_next = tms ? UPD_DR : PAU_DR;
      PAU_DR:  w_next = tms ? EX2_DR : PAU_DR;
      EX2_DR:  w_next = tms ? UPD_DR : SH_DR;
      UPD_DR:  w_next = tms ? SEL_DR : RTI;
      SEL_IR:  w_next = tms ? TLR    : CAP_IR;
      CAP_IR:  w_next = tms ? EX1_IR : SH_IR;
      SH_IR:   w_next = tms ? EX1_IR : SH_IR;
      EX1_IR:  w_next = tms ? UPD_IR : PAU_IR;
      PAU_IR:  w_next = tms ? EX2_IR : PAU_IR;
      EX2_IR:  w_next = tms ? UPD_IR : SH_IR;
      UPD_IR:  w_next = tms ? SEL_DR : RTI;
      default: w_next = TLR;
    endcase
  end

  // Rising-edge state: FSM, IR shift stage and bypass bit.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_state    <= TLR;
      r_ir_shift <= '0;
      r_bypass   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        TLR:     r_ir_shift <= '0;
        CAP_IR:  r_ir_shift <= IR_CAPTURE;
        SH_IR:   r_ir_shift <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
        default: r_ir_shift <= r_ir_shift;
      endcase
      case (r_state)
        TLR:     r_bypass <= 1'b0;
        CAP_DR:  r_bypass <= 1'b0;
        SH_DR:   r_bypass <= tdi;
        default: r_bypass <= r_bypass;
      endcase
    end
  end

  // Instruction decode and selection of the data register serial output.
  always_comb begin
    w_sel_idcode = (r_instruction == IDCODE_OPCODE);
`ifdef USERCODE_EN
    if (w_sel_idcode) begin
      w_dr_tdo = idcode_tdo;
    end else if (r_instruction == USERCODE_OPCODE) begin
      w_dr_tdo = user_tdo;
    end else begin
      w_dr_tdo = r_bypass;
    end
`else
    if (w_sel_idcode) begin
      w_dr_tdo = idcode_tdo;
    end else begin
      w_dr_tdo = r_bypass;
    end
`endif
  end

`ifndef USERCODE_EN
  // Without the user register, its input and its opcode have no function.
  logic w_unused;
  assign w_unused = user_tdo | (|USERCODE_OPCODE) | (&BYPASS_OPCODE);
`else
  logic w_unused;
  assign w_unused = &BYPASS_OPCODE;
`endif

  // Falling-edge control and output registers. They change only while tck is
  // low, so they are stable across the next rising edge.
  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      r_tdo         <= 1'b0;
      r_tdo_en      <= 1'b0;
      r_capture_dr  <= 1'b0;
      r_shift_dr    <= 1'b0;
      r_update_en   <= 1'b0;
      r_dr_clk_en   <= 1'b0;
      r_instruction <= IDCODE_OPCODE;
    end else if (r_state == TLR) begin
      r_tdo         <= 1'b0;
      r_tdo_en      <= 1'b0;
      r_capture_dr  <= 1'b0;
      r_shift_dr    <= 1'b0;
      r_update_en   <= 1'b0;
      r_dr_clk_en   <= 1'b0;
      r_instruction <= IDCODE_OPCODE;
    end else begin
      r_capture_dr <= (r_state == CAP_DR);
      r_shift_dr   <= (r_state == SH_DR);
      r_update_en  <= (r_state == UPD_DR);
      r_dr_clk_en  <= (r_state == CAP_DR) || (r_state == SH_DR);
      r_tdo_en     <= (r_state == SH_DR) || (r_state == SH_IR);
      if (r_state == SH_IR) begin
        r_tdo <= r_ir_shift[0];
      end else if (r_state == SH_DR) begin
        r_tdo <= w_dr_tdo;
      end else begin
        r_tdo <= 1'b0;
      end
      if (r_state == UPD_IR) begin
        r_instruction <= r_ir_shift;
      end else begin
        r_instruction <= r_instruction;
      end
    end
  end

  // dr_clk_en only moves while tck is low, so this AND cannot glitch.
  assign clock_dr      = tck & r_dr_clk_en;
  // Update-DR strobe covers the low half of tck after the falling edge.
  assign update_dr     = r_update_en & ~tck;
  assign capture_dr    = r_capture_dr;
  assign shift_dr      = r_shift_dr;
  assign tdo           = r_tdo;
  assign tdo_en        = r_tdo_en;
  assign dr_tdi        = tdi;
  assign select_idcode = w_sel_idcode;
  assign instruction   = r_instruction;

endmodule

// File: tb/tb_tap_controller.sv
module tb_tap_controller;

  localparam logic [31:0] ID_VALUE = 32'h1234_5677;

  logic       tck = 1'b0;
  logic       trst = 1'b1;
  logic       tms = 1'b0;
  logic       tdi = 1'b0;
  logic       user_tdo = 1'b0;
  logic       idcode_tdo;
  logic       tdo, tdo_en, dr_tdi, clock_dr, capture_dr, shift_dr, update_dr;
  logic       select_idcode;
  logic [3:0] instruction;

  logic [31:0] id_model = 32'h0;
  logic        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          clk_cnt = 0;
  int          cap_cnt = 0;
  int          upd_cnt = 0;

  tap_controller dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .dr_tdi(dr_tdi), .clock_dr(clock_dr), .capture_dr(capture_dr),
    .shift_dr(shift_dr), .update_dr(update_dr), .select_idcode(select_idcode),
    .idcode_tdo(idcode_tdo), .user_tdo(user_tdo), .instruction(instruction)
  );

  always #10 tck = ~tck;

  // Identification register model: loads on the capture pulse, shifts right.
  assign idcode_tdo = id_model[0];
  always @(posedge clock_dr) begin
    clk_cnt <= clk_cnt + 1;
    if (capture_dr) id_model <= ID_VALUE;
    else if (shift_dr) id_model <= {1'b0, id_model[31:1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected tdo bit for each cycle the DUT drives tdo.
  initial begin
    logic e;
    forever begin
      @(negedge tck);
      #1;
      if (capture_dr) cap_cnt++;
      if (update_dr) upd_cnt++;
      if (tdo_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tdo_unexpected: got %0b with empty queue (t=%0t)", tdo, $time);
        end else begin
          e = exp_q.pop_front();
          check("tdo", {31'h0, tdo}, {31'h0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic settle();
    @(negedge tck);
    #2;
  endtask

  // DR scan of n bits starting and ending in Run-Test/Idle.
  task automatic dr_scan(input logic [31:0] bits, input int n);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 0; k < n; k++) tick((k == n - 1), bits[k]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    settle();
  endtask

  // IR scan from Run-Test/Idle. Instruction must only change after the
  // Update-IR falling edge.
  task automatic ir_scan(input logic [31:0] bits, input int n,
                         input logic [3:0] prev, input logic [3:0] nxt);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 0; k < n; k++) tick((k == n - 1), bits[k]);
    tick(1'b1, 1'b0);
    check("instr_before_update", {28'h0, instruction}, {28'h0, prev});
    settle();
    check("instr_after_update", {28'h0, instruction}, {28'h0, nxt});
    tick(1'b0, 1'b0);
    settle();
  endtask

  initial begin
    // Reset state.
    #25;
    check("rst_instruction", {28'h0, instruction}, 32'h1);
    check("rst_select_idcode", {31'h0, select_idcode}, 32'h1);
    check("rst_tdo", {31'h0, tdo}, 32'h0);
    check("rst_tdo_en", {31'h0, tdo_en}, 32'h0);
    check("rst_capture_dr", {31'h0, capture_dr}, 32'h0);
    check("rst_shift_dr", {31'h0, shift_dr}, 32'h0);
    check("rst_update_dr", {31'h0, update_dr}, 32'h0);
    check("rst_clock_dr", {31'h0, clock_dr}, 32'h0);
    @(negedge tck);
    #2;
    trst = 1'b0;

    // IDCODE scan: 32 bits LSB first, 33 clock_dr pulses.
    clk_cnt = 0; cap_cnt = 0; upd_cnt = 0;
    tick(1'b0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      logic [31:0] idv;
      idv = ID_VALUE;
      exp_q.push_back(idv[k]);
    end
    dr_scan(32'h0, 32);
    check("idcode_clock_dr_pulses", clk_cnt, 32'd33);
    check("idcode_capture_cycles", cap_cnt, 32'd1);
    check("idcode_update_cycles", upd_cnt, 32'd1);
    check("idcode_queue_drained", exp_q.size(), 32'd0);

    // IR scan loading BYPASS: captured 0001 shifts out LSB first.
    clk_cnt = 0; cap_cnt = 0;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    ir_scan(32'hF, 4, 4'b0001, 4'b1111);
    check("bypass_select_idcode", {31'h0, select_idcode}, 32'h0);
    check("ir_scan_clock_dr_pulses", clk_cnt, 32'd0);
    check("ir_scan_capture_cycles", cap_cnt, 32'd0);

    // Bypass: tdi 1,0,1,1 -> tdo 0,1,0,1.
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    dr_scan(32'b1101, 4);
    check("bypass_queue_drained", exp_q.size(), 32'd0);

    // Update-DR reached without Shift-DR still strobes update_dr.
    clk_cnt = 0; cap_cnt = 0; upd_cnt = 0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    settle();
    check("noshift_update_cycles", upd_cnt, 32'd1);
    check("noshift_clock_dr_pulses", clk_cnt, 32'd1);
    check("noshift_capture_cycles", cap_cnt, 32'd1);

    // USERCODE opcode: user register when enabled, bypass otherwise.
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    ir_scan(32'b0010, 4, 4'b1111, 4'b0010);
    check("usercode_select_idcode", {31'h0, select_idcode}, 32'h0);
    user_tdo = 1'b1;
`ifdef USERCODE_EN
    for (int k = 0; k < 5; k++) exp_q.push_back(1'b1);
`else
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
`endif
    dr_scan(32'b01011, 5);
    user_tdo = 1'b0;
    check("usercode_queue_drained", exp_q.size(), 32'd0);

    // Pause-IR then five tms=1 edges reach Test-Logic-Reset on the fifth.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    settle();
    check("pause_ir_instr_held", {28'h0, instruction}, 32'h2);
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0);
    settle();
    check("tms4_instr_updated", {28'h0, instruction}, 32'hF);
    tick(1'b1, 1'b0);
    settle();
    check("tms5_instr_reset", {28'h0, instruction}, 32'h1);
    check("tms5_select_idcode", {31'h0, select_idcode}, 32'h1);

    // trst in the middle of a bypass Shift-DR.
    tick(1'b0, 1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    ir_scan(32'hF, 4, 4'b0001, 4'b1111);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    tick(1'b0, 1'b1);
    settle();
    check("midscan_shift_dr", {31'h0, shift_dr}, 32'h1);
    @(posedge tck);
    #1;
    check("midscan_clock_dr_high", {31'h0, clock_dr}, 32'h1);
    trst = 1'b1;
    #1;
    check("trst_clock_dr", {31'h0, clock_dr}, 32'h0);
    check("trst_shift_dr", {31'h0, shift_dr}, 32'h0);
    check("trst_tdo_en", {31'h0, tdo_en}, 32'h0);
    check("trst_tdo", {31'h0, tdo}, 32'h0);
    check("trst_instruction", {28'h0, instruction}, 32'h1);
    check("trst_select_idcode", {31'h0, select_idcode}, 32'h1);
    settle();
    trst = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    settle();
    check("post_trst_instruction", {28'h0, instruction}, 32'h1);
    check("post_trst_capture_dr", {31'h0, capture_dr}, 32'h0);
    check("post_trst_shift_dr", {31'h0, shift_dr}, 32'h0);
    check("post_trst_tdo_en", {31'h0, tdo_en}, 32'h0);
    check("final_queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
